multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 143 ++++++++++++++
 tb/tb_multdiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: one radix-2 step per cycle,
// fixed 33-edge latency from the start edge to the registered result strobe.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [5:0]  count;

    logic [63:0] prod;
    logic [63:0] mcand;
    logic [31:0] mplier;

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        res_neg;
    logic        b_zero;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod_step;
    logic        mul_ovf;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] quo_signed;
    logic        div_ovf;

    always_comb begin
        abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

        // Bit 31 of a two's-complement multiplier carries negative weight.
        prod_step = prod;
        if (mplier[0]) begin
            if (count == 6'd31)
                prod_step = prod - mcand;
            else
                prod_step = prod + mcand;
        end
        mul_ovf = !((&prod[63:31]) || !(|prod[63:31]));

        shifted    = {rem, quo[31]};
        diff       = shifted - {1'b0, dvs};
        fits       = (shifted >= {1'b0, dvs});
        quo_signed = res_neg ? (~quo + 32'd1) : quo;
        // Only 0x80000000 / -1 yields a positive magnitude of 2^31.
        div_ovf    = !res_neg && quo[31];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            prod           <= '0;
            mcand          <= '0;
            mplier         <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            res_neg        <= 1'b0;
            b_zero         <= 1'b0;
        end else if (ctrl_MULT) begin
            state          <= MUL;
            count          <= '0;
            data_resultRDY <= 1'b0;
            prod           <= '0;
            mcand          <= {{32{data_operandA[31]}}, data_operandA};
            mplier         <= data_operandB;
        end else if (ctrl_DIV) begin
            state          <= DIV;
            count          <= '0;
            data_resultRDY <= 1'b0;
            rem            <= '0;
            quo            <= abs_a;
            dvs            <= abs_b;
            res_neg        <= data_operandA[31] ^ data_operandB[31];
            b_zero         <= (data_operandB == 32'd0);
        end else begin
            case (state)
                IDLE: begin
                    data_resultRDY <= 1'b0;
                end
                MUL: begin
                    if (count == 6'd32) begin
                        data_result    <= prod[31:0];
                        data_exception <= mul_ovf;
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end else begin
                        prod   <= prod_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 6'd1;
                    end
                end
                DIV: begin
                    if (count == 6'd32) begin
                        if (b_zero) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= quo_signed;
                            data_exception <= div_ovf;
                        end
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end else begin
                        rem   <= fits ? diff[31:0] : shifted[31:0];
                        quo   <= {quo[30:0], fits};
                        count <= count + 6'd1;
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed vector table, hand-written restart/reset
// sequences, and random operands checked against a 64-bit arithmetic model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_unit dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        is_div;
        logic [31:0] exp_r;
        logic        exp_e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic is_div,
                                  output logic [31:0] r, output logic e);
        longint p;
        longint q;
        if (!is_div) begin
            p = longint'($signed(x)) * longint'($signed(y));
            r = p[31:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (y == 32'd0) begin
            r = '0;
            e = 1'b1;
        end else begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = q[31:0];
            e = (q > 64'sd2147483647);
        end
    endfunction

    task automatic start(input logic [31:0] x, input logic [31:0] y, input logic m, input logic d);
        @(negedge clock);
        data_operandA = x;
        data_operandB = y;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic m, input logic d, input logic [31:0] er, input logic ee);
        int lat;
        start(x, y, m, d);
        wait_rdy(lat);
        check({name, " latency"}, lat, 33);
        check({name, " result"}, data_result, er);
        check({name, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        @(posedge clock);
        #1;
        check({name, " rdy width"}, {31'd0, data_resultRDY}, 32'd0);
        check({name, " hold"}, data_result, er);
    endtask

    vec_t vecs[11];

    initial begin
        logic [31:0] er;
        logic        ee;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rdy_seen;
        int          lat;

        vecs[0]  = '{32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1};
        vecs[3]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{32'd100,      32'hFFFFFFF6, 1'b1, 32'hFFFFFFF6, 1'b0};
        vecs[5]  = '{32'd5,        32'd0,        1'b1, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1};
        vecs[7]  = '{32'd0,        32'd7,        1'b1, 32'h00000000, 1'b0};
        vecs[8]  = '{32'h7FFFFFFF, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b0};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0};
        vecs[10] = '{32'h80000000, 32'd1,        1'b0, 32'h80000000, 1'b0};

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, !vecs[i].is_div, vecs[i].is_div,
                   vecs[i].exp_r, vecs[i].exp_e);

        // Both starts on one edge: multiply takes precedence.
        run_op("both starts", 32'd6, 32'd3, 1'b1, 1'b1, 32'd18, 1'b0);

        // Restart: a divide issued 10 cycles into a multiply replaces it.
        start(32'd3, 32'd4, 1'b1, 1'b0);
        rdy_seen = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen = 1'b1;
        end
        start(32'd9, 32'd3, 1'b0, 1'b1);
        if (data_resultRDY) rdy_seen = 1'b1;
        check("restart no mult pulse", {31'd0, rdy_seen}, 32'd0);
        wait_rdy(lat);
        check("restart latency", lat, 33);
        check("restart result", data_result, 32'd3);
        check("restart exception", {31'd0, data_exception}, 32'd0);

        // Reset on cycle 15 of a multiply aborts it silently.
        start(32'd1234, 32'd5678, 1'b1, 1'b0);
        repeat (13) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset result", data_result, 32'd0);
        check("midreset exception", {31'd0, data_exception}, 32'd0);
        check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen = 1'b1;
        end
        check("midreset no pulse", {31'd0, rdy_seen}, 32'd0);
        check("midreset idle result", data_result, 32'd0);
        run_op("after reset 2x2", 32'd2, 32'd2, 1'b1, 1'b0, 32'd4, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic isd;
            isd = (i % 2) == 1;
            ra  = (i % 3 == 0) ? ($urandom_range(0, 2000) - 1000) : $urandom;
            rb  = (i % 4 == 0) ? ($urandom_range(0, 64) - 32) : $urandom;
            model(ra, rb, isd, er, ee);
            run_op($sformatf("rand%0d %s %h %h", i, isd ? "div" : "mul", ra, rb), ra, rb,
                   !isd, isd, er, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
